branch_redirect_unit: RTL and testbench
=======================================

// Module: branch_redirect_unit
// PURPOSE
//  Consumes the ID-stage branch comparator's Result plus the decoded branch or jump target.
//  Produces a registered PC redirect request to the fetch stage, with a valid/ready handshake.
//  Produces the IF/ID flush and the ID back-pressure (Busy) that make redirects precise.
//  Sits between the ID-stage comparator and the PC register.
// PARAMETERS
//  WIDTH       32  address width
//  DELAY_SLOT  1   1: delay-slot instruction survives (no flush); 0: IF/ID flushed on redirect
//  CNT_W       16  width of statistics counters (only with BRANCH_STATS_EN)
// PORTS
//  Clock         in   1      system clock, rising edge
//  Reset         in   1      asynchronous, active-low (0 = reset)
//  BranchValid   in   1      ID holds a conditional branch whose CmpResult is valid this cycle
//  CmpResult     in   1      comparator outcome, 1 = taken
//  BranchTarget  in   WIDTH  PC+4+(sext(imm)<<2), computed in ID
//  JumpValid     in   1      ID holds an unconditional J/JAL/JR (always taken)
//  JumpTarget    in   WIDTH  jump destination
//  Stall         in   1      ID stage stalled; the instruction in ID is not advancing
//  PcReady       in   1      fetch accepts RedirectPC at this edge
//  RedirectValid out  1      redirect request pending
//  RedirectPC    out  WIDTH  target, bits[1:0] forced 0
//  FlushIFID     out  1      one-cycle flush pulse to IF/ID (only when DELAY_SLOT=0)
//  Busy          out  1      combinational; = (state != IDLE); ID must stall while high
//  Misalign      out  1      one-cycle pulse: accepted target had bits[1:0] != 0
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; RedirectValid, RedirectPC, FlushIFID and Misalign all 0.
//  FSM states: IDLE, REDIRECT.
//  IDLE, acceptance:
//   - Event "accept" = !Stall && (JumpValid || (BranchValid && CmpResult)).
//   - JumpValid has priority over BranchValid if both are high.
//   - On accept at edge N: RedirectPC <= target&~3; RedirectValid <= 1; state <= REDIRECT.
//   - Also at edge N: FlushIFID <= !DELAY_SLOT; Misalign <= |target[1:0].
//   - So the redirect is visible in cycle N+1 (1-cycle latency).
//   - Not-taken branch or Stall=1: no action; the unit stays in IDLE.
//  REDIRECT:
//   - RedirectValid and RedirectPC are held stable until PcReady=1 is sampled at an edge.
//   - At that edge: RedirectValid <= 0; state <= IDLE.
//   - The earliest new acceptance is the following edge.
//  FlushIFID and Misalign are single-cycle pulses.
//   - They clear at the edge after they are set, independent of PcReady.
//  Busy is high throughout REDIRECT.
//   - BranchValid and JumpValid are ignored there; nothing is queued or dropped silently,
//     because ID is stalled by Busy.
//  PcReady while RedirectValid=0 has no effect.
//  RedirectValid deasserting and a new accept never occur on the same edge.
// CONFIGURATION
//  Macro BRANCH_STATS_EN.
//  Defined:
//   - Adds outputs BranchCount and TakenCount, each [CNT_W-1:0].
//   - BranchCount += 1 for every !Stall && BranchValid in IDLE.
//   - TakenCount += 1 for every accepted conditional branch (jumps are not counted).
//   - Both counters saturate at all-ones and async-reset to 0.
//  Undefined: neither port nor counter logic exists; all other behaviour is identical.
// STRUCTURE
//  Shared package icarus_pkg: typedef of the FSM state (IDLE=1'b0, REDIRECT=1'b1).
//  Also in icarus_pkg: WORD_ALIGN_MASK and the shared address width.
//  Sub-module sat_counter (CNT_W, inc, count), instantiated twice under BRANCH_STATS_EN.
//  There are no other sub-modules.
// TESTING
//  T1: Reset=0 mid-REDIRECT with RedirectValid=1.
//      -> all outputs 0 immediately (before the clock edge); state IDLE.
//  T2: BranchValid=1, CmpResult=1, BranchTarget=0x0040_0020, PcReady=1.
//      -> next cycle RedirectValid=1, RedirectPC=0x0040_0020.
//      -> the cycle after that, RedirectValid=0 and Busy=0.
//  T3: Same as T2 but PcReady=0 for 3 cycles.
//      -> RedirectValid and PC held for 3 cycles, Busy=1.
//      -> a second BranchValid during the hold is ignored.
//  T4: BranchValid=1, CmpResult=0 -> no redirect, Busy stays 0.
//      With Stall=1 and CmpResult=1 -> no redirect.
//  T5: JumpValid=1 (JumpTarget=0x100) and taken BranchValid (target 0x200) together.
//      -> RedirectPC=0x100.
//      -> with DELAY_SLOT=0, FlushIFID is a 1-cycle pulse.
//  T6: JumpTarget=0x0000_0103 -> RedirectPC=0x100, Misalign pulse.
//      With BRANCH_STATS_EN, after 3 taken + 2 not-taken branches: Branch=5, Taken=3.

Source files
------------

// File: rtl/icarus_pkg.sv
// Shared types and constants for the branch redirect path: FSM state encoding,
// default address width and the word-alignment mask applied to redirect targets.
package icarus_pkg;

  localparam int ADDR_W = 32;

  // Low address bits that must be zero for a word-aligned instruction fetch.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } redirect_state_e;

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return |(lsbs & WORD_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, async-reset to 0.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count, holding once every bit is set.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_redirect_unit.sv
// ID-stage branch/jump redirect: registers a PC redirect for fetch with valid/ready,
// flush and misalign pulses. Optional BRANCH_STATS_EN adds branch/taken counters.
module branch_redirect_unit
  import icarus_pkg::*;
#(
  parameter int WIDTH      = ADDR_W,
  parameter bit DELAY_SLOT = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             BranchValid,
  input  logic             CmpResult,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             JumpValid,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Stall,
  input  logic             PcReady,
  output logic             RedirectValid,
  output logic [WIDTH-1:0] RedirectPC,
  output logic             FlushIFID,
  output logic             Busy,
  output logic             Misalign
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] TakenCount
`endif
);

  redirect_state_e  state_d, state_q;
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] pc_d, pc_q;
  logic             flush_d, flush_q;
  logic             misalign_d, misalign_q;
  logic             accept_s;
  logic [WIDTH-1:0] target_s;

  // Jumps are always taken and win over a simultaneous conditional branch.
  assign accept_s = !Stall && (JumpValid || (BranchValid && CmpResult));
  assign target_s = JumpValid ? JumpTarget : BranchTarget;

  // Next-state and next-output computation for the redirect FSM.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d    = REDIRECT;
          valid_d    = 1'b1;
          pc_d       = target_s & ~{{(WIDTH-2){1'b0}}, WORD_ALIGN_MASK};
          flush_d    = ~DELAY_SLOT;
          misalign_d = is_misaligned(target_s[1:0]);
        end else begin
          state_d = IDLE;
        end
      end
      REDIRECT: begin
        // ID is held by Busy here, so incoming branch/jump requests are not lost.
        if (PcReady) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = REDIRECT;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      pc_q       <= {WIDTH{1'b0}};
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign RedirectValid = valid_q;
  assign RedirectPC    = pc_q;
  assign FlushIFID     = flush_q;
  assign Misalign      = misalign_q;
  assign Busy          = (state_q != IDLE);

`ifdef BRANCH_STATS_EN
  logic branch_inc_s;
  logic taken_inc_s;

  // A branch paired with a jump is seen but not taken: the jump wins.
  assign branch_inc_s = (state_q == IDLE) && !Stall && BranchValid;
  assign taken_inc_s  = branch_inc_s && CmpResult && !JumpValid;

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (Clock),
    .rst_n (Reset),
    .inc   (branch_inc_s),
    .count (BranchCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (Clock),
    .rst_n (Reset),
    .inc   (taken_inc_s),
    .count (TakenCount)
  );
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit (built with DELAY_SLOT=0 so flush pulses are visible).
module tb_branch_redirect_unit;

  localparam int W = 32;
  localparam int N_VEC = 14;

  logic         clk;
  logic         rst_n;
  logic         bv, cmp, jv, stall, rdy;
  logic [W-1:0] bt, jt;
  logic         rv, flush, busy, mis;
  logic [W-1:0] pc;
`ifdef BRANCH_STATS_EN
  logic [15:0]  bcnt, tcnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         bv, cmp, jv, stall, rdy;
    logic [W-1:0] bt, jt;
    logic         e_rv;
    logic [W-1:0] e_pc;
    logic         e_flush, e_busy, e_mis;
  } vec_t;

  vec_t vec [N_VEC];

  branch_redirect_unit #(.WIDTH(W), .DELAY_SLOT(1'b0), .CNT_W(16)) dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .BranchValid  (bv),
    .CmpResult    (cmp),
    .BranchTarget (bt),
    .JumpValid    (jv),
    .JumpTarget   (jt),
    .Stall        (stall),
    .PcReady      (rdy),
    .RedirectValid(rv),
    .RedirectPC   (pc),
    .FlushIFID    (flush),
    .Busy         (busy),
    .Misalign     (mis)
`ifdef BRANCH_STATS_EN
    ,
    .BranchCount  (bcnt),
    .TakenCount   (tcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic c, input logic [W-1:0] btg,
                       input logic j, input logic [W-1:0] jtg, input logic s, input logic r);
    bv = b; cmp = c; bt = btg; jv = j; jt = jtg; stall = s; rdy = r;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rv"},    {63'd0, rv},    64'd0);
    check({tag, "_pc"},    {32'd0, pc},    64'd0);
    check({tag, "_flush"}, {63'd0, flush}, 64'd0);
    check({tag, "_busy"},  {63'd0, busy},  64'd0);
    check({tag, "_mis"},   {63'd0, mis},   64'd0);
  endtask

  initial begin
    // bv cmp jv stall rdy | bt jt | rv pc flush busy mis
    vec[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0020, 32'h0, 1'b1, 32'h0040_0020, 1'b1, 1'b1, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0103, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b1};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vec[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vec[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0FFE, 32'h0, 1'b1, 32'h0000_0FFC, 1'b1, 1'b1, 1'b1};
    vec[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vec[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle_outputs("post_reset");

    // Table: each row is driven for one edge, outputs checked just after it.
    for (int i = 0; i < N_VEC; i++) begin
      drive(vec[i].bv, vec[i].cmp, vec[i].bt, vec[i].jv, vec[i].jt, vec[i].stall, vec[i].rdy);
      tick();
      check($sformatf("v%0d_rv", i),    {63'd0, rv},    {63'd0, vec[i].e_rv});
      check($sformatf("v%0d_flush", i), {63'd0, flush}, {63'd0, vec[i].e_flush});
      check($sformatf("v%0d_busy", i),  {63'd0, busy},  {63'd0, vec[i].e_busy});
      check($sformatf("v%0d_mis", i),   {63'd0, mis},   {63'd0, vec[i].e_mis});
      if (vec[i].e_rv) check($sformatf("v%0d_pc", i), {32'd0, pc}, {32'd0, vec[i].e_pc});
    end

    // Hold under back-pressure; a branch arriving during the hold is ignored.
    drive(1'b1, 1'b1, 32'h0040_0020, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("hold_accept_rv", {63'd0, rv}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      drive((k == 1) ? 1'b1 : 1'b0, 1'b1, 32'h0000_0800, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      check($sformatf("hold%0d_rv", k),   {63'd0, rv},   64'd1);
      check($sformatf("hold%0d_pc", k),   {32'd0, pc},   64'h0040_0020);
      check($sformatf("hold%0d_busy", k), {63'd0, busy}, 64'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    check("hold_release_rv",   {63'd0, rv},   64'd0);
    check("hold_release_busy", {63'd0, busy}, 64'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("hold_no_queue_rv", {63'd0, rv}, 64'd0);

    // Asynchronous reset in the middle of a pending redirect.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    tick();
    check("pre_areset_rv", {63'd0, rv}, 64'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("areset");
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_outputs("after_areset");

`ifdef BRANCH_STATS_EN
    check("stats_reset_b", {48'd0, bcnt}, 64'd0);
    check("stats_reset_t", {48'd0, tcnt}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 32'h0000_0400, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 32'h0000_0400, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("stats_branch", {48'd0, bcnt}, 64'd5);
    check("stats_taken",  {48'd0, tcnt}, 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
